// File: rtl/exc_commit_ctrl.sv
// Commit-side exception / ERTN controller at the WB stage.
// It prioritises fault flags into an ecode, pulses the CSR update, flushes IF..MEM and redirects pre-IF.
module exc_commit_ctrl #(
    parameter int FLUSH_HOLD = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic [5:0]  wb_exc,
    input  logic        wb_ertn,
    input  logic [31:0] ex_entry,
    input  logic [31:0] er_entry,
    output logic        wb_allowin,
    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_ex_pc,
    output logic        ertn_flush,
    output logic        flush_all,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    localparam logic [2:0] HOLD_INIT = 3'(FLUSH_HOLD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REDIR = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [31:0] r_target;

    logic        w_fault;
    logic        w_commit;
    logic        w_ex_fire;
    logic        w_ertn_fire;
    logic [5:0]  w_ecode;

    // Commits are masked while resetn is low so every output shows its reset value during reset.
    assign w_fault     = |wb_exc;
    assign w_commit    = resetn & wb_valid & wb_allowin;
    assign w_ex_fire   = w_commit & w_fault;
    assign w_ertn_fire = w_commit & wb_ertn & ~w_fault;

    // wb_exc bit order is {ale,ine,brk,sys,adef,int}; the chain below encodes the priority.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_ecode = 6'h00;
        if (wb_exc[0])      w_ecode = 6'h00;
        else if (wb_exc[1]) w_ecode = 6'h08;
        else if (wb_exc[4]) w_ecode = 6'h0D;
        else if (wb_exc[2]) w_ecode = 6'h0B;
        else if (wb_exc[3]) w_ecode = 6'h0C;
        else if (wb_exc[5]) w_ecode = 6'h09;
    end

    assign wb_allowin     = (r_state == S_IDLE) && (r_cnt == 3'd0);
    assign wb_ex          = w_ex_fire;
    assign wb_ecode       = w_ex_fire ? w_ecode : 6'h00;
    assign wb_esubcode    = 9'h000;
    assign wb_ex_pc       = w_ex_fire ? wb_pc : 32'h0;
    assign ertn_flush     = w_ertn_fire;
    assign flush_all      = w_ex_fire | w_ertn_fire | (r_state != S_IDLE);
    assign redirect_valid = (r_state == S_REDIR);
    assign redirect_pc    = (r_state == S_REDIR) ? r_target : 32'h0;

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= 3'd0;
            r_target <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ex_fire) begin
                        r_target <= ex_entry;
                        r_state  <= S_REDIR;
                    end else if (w_ertn_fire) begin
                        r_target <= er_entry;
                        r_state  <= S_REDIR;
                    end
                end
                S_REDIR: begin
                    // Target is frozen here; CSR writes landing during the stall cannot move it.
                    if (redirect_ready) begin
                        if (HOLD_INIT == 3'd0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt   <= HOLD_INIT;
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (r_cnt <= 3'd1) begin
                        r_cnt   <= 3'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: begin
                    r_cnt   <= 3'd0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Scoreboard bench for exc_commit_ctrl: stimulus pushes per-cycle expectations from a
// transaction-level model; a negedge monitor pops and compares them against the DUT.
module tb_exc_commit_ctrl;

    localparam int FLUSH_HOLD = 1;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        wb_valid = 1'b0;
    logic [31:0] wb_pc = '0;
    logic [5:0]  wb_exc = '0;
    logic        wb_ertn = 1'b0;
    logic [31:0] ex_entry = '0;
    logic [31:0] er_entry = '0;
    logic        redirect_ready = 1'b0;
    logic        wb_allowin, wb_ex, ertn_flush, flush_all, redirect_valid;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_ex_pc, redirect_pc;

    exc_commit_ctrl #(.FLUSH_HOLD(FLUSH_HOLD)) dut (
        .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_exc(wb_exc),
        .wb_ertn(wb_ertn), .ex_entry(ex_entry), .er_entry(er_entry), .wb_allowin(wb_allowin),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_ex_pc(wb_ex_pc),
        .ertn_flush(ertn_flush), .flush_all(flush_all), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        allowin;
        logic        ex;
        logic [5:0]  ecode;
        logic [31:0] ex_pc;
        logic        ertn;
        logic        flush;
        logic        rv;
        logic [31:0] rpc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: an outstanding redirect is a one-entry queue of targets,
    // followed by a count of post-handshake flush cycles.
    logic [31:0] m_pend[$];
    int          m_hold = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] exp_ecode(input logic [5:0] exc);
        int         order[6] = '{0, 1, 4, 2, 3, 5};
        logic [5:0] codes[6] = '{6'h00, 6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};
        for (int k = 0; k < 6; k++)
            if (exc[order[k]]) return codes[k];
        return 6'h00;
    endfunction

    task automatic cycle(input logic rst, input logic v, input logic [31:0] pc, input logic [5:0] exc,
                         input logic ertn, input logic [31:0] eent, input logic [31:0] erent,
                         input logic rdy);
        exp_t e;
        logic allow, exf, erf;
        @(posedge clk);
        #1;
        resetn = rst; wb_valid = v; wb_pc = pc; wb_exc = exc; wb_ertn = ertn;
        ex_entry = eent; er_entry = erent; redirect_ready = rdy;
        if (!rst) begin
            m_pend.delete();
            m_hold = 0;
            e = '{allowin: 1'b1, ex: 1'b0, ecode: 6'h00, ex_pc: 32'h0,
                  ertn: 1'b0, flush: 1'b0, rv: 1'b0, rpc: 32'h0};
        end else begin
            allow = (m_pend.size() == 0) && (m_hold == 0);
            exf   = v && allow && (exc != 6'b0);
            erf   = v && allow && ertn && (exc == 6'b0);
            e.allowin = allow;
            e.ex      = exf;
            e.ecode   = exp_ecode(exc);
            e.ex_pc   = pc;
            e.ertn    = erf;
            e.rv      = (m_pend.size() != 0);
            e.rpc     = e.rv ? m_pend[0] : 32'h0;
            e.flush   = exf || erf || e.rv || (m_hold > 0);
            if (m_pend.size() != 0) begin
                if (rdy) begin
                    m_pend.delete();
                    m_hold = FLUSH_HOLD;
                end
            end else if (m_hold > 0) begin
                m_hold--;
            end else if (exf) begin
                m_pend.push_back(eent);
            end else if (erf) begin
                m_pend.push_back(erent);
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 32'h0, 6'b0, 1'b0, 32'h0, 32'h0, rdy);
    endtask

    task automatic fault(input logic [5:0] exc, input logic ertn, input logic [31:0] pc,
                         input logic [31:0] eent, input logic [31:0] erent);
        cycle(1'b1, 1'b1, pc, exc, ertn, eent, erent, 1'b0);
    endtask

    // Monitor: one expectation per cycle, compared away from the active edge.
    int cyc = 0;
    int last_ex = -1000;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wb_allowin", 32'(wb_allowin), 32'(e.allowin));
                check("wb_ex", 32'(wb_ex), 32'(e.ex));
                check("ertn_flush", 32'(ertn_flush), 32'(e.ertn));
                check("flush_all", 32'(flush_all), 32'(e.flush));
                check("redirect_valid", 32'(redirect_valid), 32'(e.rv));
                check("wb_esubcode", 32'(wb_esubcode), 32'h0);
                if (e.ex) begin
                    check("wb_ecode", 32'(wb_ecode), 32'(e.ecode));
                    check("wb_ex_pc", wb_ex_pc, e.ex_pc);
                end
                if (e.rv) check("redirect_pc", redirect_pc, e.rpc);
            end
            if (!resetn) last_ex = -1000;
            else if (wb_ex) begin
                check("ex_spacing_ok", 32'(cyc - last_ex >= 2 + FLUSH_HOLD), 32'h1);
                last_ex = cyc;
            end
        end
    end

    initial begin
        logic        r, v, er, rdy;
        logic [5:0]  x;
        // Reset state
        cycle(1'b0, 1'b0, 32'h0, 6'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 32'h1c000000, 6'b000001, 1'b0, 32'h1c008000, 32'h0, 1'b1);
        idle(2, 1'b0);

        // sys fault, redirect accepted at once, one hold cycle, then allowin
        fault(6'b000100, 1'b0, 32'h1c000100, 32'h1c008000, 32'h0);
        idle(1, 1'b1);
        idle(2, 1'b0);

        // Priority: int+ale, then ale+adef
        fault(6'b100001, 1'b0, 32'h1c000200, 32'h1c008000, 32'h0);
        idle(3, 1'b1);
        fault(6'b100010, 1'b0, 32'h1c000204, 32'h1c008000, 32'h0);
        idle(3, 1'b1);

        // ERTN alone, then ERTN with ine
        fault(6'b000000, 1'b1, 32'h1c000300, 32'h1c008000, 32'h1c000104);
        idle(3, 1'b1);
        fault(6'b010000, 1'b1, 32'h1c000304, 32'h1c008000, 32'h1c000104);
        idle(3, 1'b1);

        // Stall redirect for 5 cycles with new ex_entry and more commit attempts
        fault(6'b001000, 1'b0, 32'h1c000400, 32'h1c00a000, 32'h0);
        for (int k = 0; k < 5; k++)
            cycle(1'b1, 1'b1, 32'h1c000404, 6'b000100, 1'b0, 32'h1c00b000 + 32'(k), 32'h0, 1'b0);
        idle(3, 1'b1);

        // Reset in REDIR, then in HOLD; no redirect afterwards
        fault(6'b000100, 1'b0, 32'h1c000500, 32'h1c00c000, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 6'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(3, 1'b1);
        fault(6'b000100, 1'b0, 32'h1c000504, 32'h1c00c000, 32'h0);
        idle(1, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 6'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(3, 1'b1);

        // Back-to-back faulting commits
        for (int k = 0; k < 30; k++)
            cycle(1'b1, 1'b1, 32'h1c001000 + 32'(4 * k), 6'($urandom_range(1, 63)),
                  1'($urandom), $urandom, $urandom, 1'b1);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            r   = ($urandom_range(0, 199) != 0);
            v   = ($urandom_range(0, 9) < 7);
            x   = ($urandom_range(0, 1) == 0) ? 6'b0 : 6'($urandom);
            er  = ($urandom_range(0, 9) < 3);
            rdy = 1'($urandom);
            cycle(r, v, $urandom, x, er, $urandom, $urandom, rdy);
        end

        idle(2, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
